// File: rtl/trace_feeder.sv
// Trace replay engine: reads addresses from a trace memory and presents them one at a
// time to a cache, waiting for a hit/fill response (or a timeout) between entries.
module trace_feeder #(
    parameter int IDX_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W:0]   trace_len,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_addr,
    input  logic [31:0]      rd_data,
    output logic             trace_ready,
    output logic [31:0]      mem_addr,
    input  logic             found_in_cache,
    input  logic             updated,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [31:0]      issued_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_ISSUE,
        S_WAIT_RESP,
        S_DONE
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [IDX_W:0]   len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [15:0]      wait_q, wait_d;
    logic             terr_q, terr_d;

    logic             resp;
    logic [IDX_W:0]   idx_inc;

    // idx_inc is one bit wider than idx so a full 2^IDX_W trace ends cleanly instead of wrapping
    assign resp    = found_in_cache | updated;
    assign idx_inc = {1'b0, idx_q} + (IDX_W+1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            mem_addr_q <= '0;
            cnt_q      <= '0;
            wait_q     <= '0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            terr_q     <= terr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        mem_addr_d  = mem_addr_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        terr_d      = terr_q;
        rd_en       = 1'b0;
        trace_ready = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    len_d   = trace_len;
                    idx_d   = '0;
                    cnt_d   = '0;
                    wait_d  = '0;
                    terr_d  = 1'b0;
                    state_d = (trace_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                rd_en   = 1'b1;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                mem_addr_d = rd_data;
                state_d    = S_ISSUE;
            end
            S_ISSUE: begin
                trace_ready = 1'b1;
                cnt_d       = cnt_q + 32'd1;
                wait_d      = '0;
                state_d     = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                // A response in the timeout cycle wins over the timeout
                if (resp) begin
                    if (idx_inc < len_q) begin
                        idx_d   = idx_inc[IDX_W-1:0];
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    terr_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_addr      = idx_q;
    assign mem_addr     = mem_addr_q;
    assign issued_count = cnt_q;
    assign timeout_err  = terr_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_trace_feeder.sv
// Directed bench for trace_feeder (IDX_W=3 so a full-depth trace is short, TIMEOUT=8).
module tb_trace_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  trace_len;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic        trace_ready;
    logic [31:0] mem_addr;
    logic        found_in_cache;
    logic        updated;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [31:0] issued_count;

    int total = 0;
    int bad   = 0;
    int tr_pulses = 0;
    int rd_pulses = 0;
    int p0, r0;

    logic [31:0] mem [8];

    always #5 clk = ~clk;

    trace_feeder #(
        .IDX_W   (3),
        .TIMEOUT (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .trace_len      (trace_len),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .trace_ready    (trace_ready),
        .mem_addr       (mem_addr),
        .found_in_cache (found_in_cache),
        .updated        (updated),
        .busy           (busy),
        .done           (done),
        .timeout_err    (timeout_err),
        .issued_count   (issued_count)
    );

    always @(negedge clk) begin
        if (trace_ready === 1'b1) tr_pulses++;
        if (rd_en === 1'b1) rd_pulses++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] len);
        start     = 1'b1;
        trace_len = len;
        tick();
        start     = 1'b0;
        trace_len = 4'd1;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_rd_en"},       {31'b0, rd_en}, 32'd0);
        chk({pfx, "_rd_addr"},     {29'b0, rd_addr}, 32'd0);
        chk({pfx, "_trace_ready"}, {31'b0, trace_ready}, 32'd0);
        chk({pfx, "_mem_addr"},    mem_addr, 32'd0);
        chk({pfx, "_busy"},        {31'b0, busy}, 32'd0);
        chk({pfx, "_done"},        {31'b0, done}, 32'd0);
        chk({pfx, "_timeout_err"}, {31'b0, timeout_err}, 32'd0);
        chk({pfx, "_issued"},      issued_count, 32'd0);
    endtask

    // From a FETCH cycle to the first WAIT_RESP cycle.
    task automatic issue_part(input int idx, input logic [31:0] addr, input logic spur,
                              input int exp_cnt);
        chk("fetch_rd_en",   {31'b0, rd_en}, 32'd1);
        chk("fetch_rd_addr", {29'b0, rd_addr}, 32'(idx));
        chk("fetch_busy",    {31'b0, busy}, 32'd1);
        rd_data = 32'hBAD0_0000;
        tick();
        chk("capture_rd_en", {31'b0, rd_en}, 32'd0);
        chk("capture_tr",    {31'b0, trace_ready}, 32'd0);
        rd_data = addr;
        tick();
        rd_data = 32'hBAD1_0000;
        chk("issue_tr",       {31'b0, trace_ready}, 32'd1);
        chk("issue_mem_addr", mem_addr, addr);
        if (spur) begin
            found_in_cache = 1'b1;
            updated        = 1'b1;
        end
        tick();
        found_in_cache = 1'b0;
        updated        = 1'b0;
        chk("wait_tr",       {31'b0, trace_ready}, 32'd0);
        chk("wait_issued",   issued_count, 32'(exp_cnt));
        chk("wait_mem_addr", mem_addr, addr);
    endtask

    // Hold WAIT_RESP for dly cycles, then respond; ends one cycle after the response edge.
    task automatic resp_part(input int dly, input logic f, input logic u, input logic bstart);
        for (int i = 0; i < dly; i++) begin
            if (bstart && i == 0) begin
                start     = 1'b1;
                trace_len = 4'd0;
            end
            tick();
            start = 1'b0;
            chk("wait_hold_tr",    {31'b0, trace_ready}, 32'd0);
            chk("wait_hold_rd_en", {31'b0, rd_en}, 32'd0);
            chk("wait_hold_busy",  {31'b0, busy}, 32'd1);
        end
        found_in_cache = f;
        updated        = u;
        tick();
        found_in_cache = 1'b0;
        updated        = 1'b0;
    endtask

    task automatic entry(input int idx, input logic [31:0] addr, input int dly, input logic f,
                         input logic u, input logic spur, input logic bstart, input int exp_cnt);
        issue_part(idx, addr, spur, exp_cnt);
        resp_part(dly, f, u, bstart);
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        trace_len      = 4'd0;
        rd_data        = 32'd0;
        found_in_cache = 1'b0;
        updated        = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 32'h1000_0000 + 32'(i * 16);
        mem[0] = 32'h100;
        mem[1] = 32'h200;
        mem[2] = 32'h300;
        mem[3] = 32'h400;
        mem[4] = 32'h500;

        repeat (2) tick();
        chk_reset_outputs("rst");
        rst = 1'b0;
        tick();
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_done", {31'b0, done}, 32'd0);

        // Basic three-entry replay, response two cycles after each trace_ready
        p0 = tr_pulses;
        do_start(4'd3);
        entry(0, 32'h100, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        entry(1, 32'h200, 1, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        entry(2, 32'h300, 1, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        chk("t1_done",     {31'b0, done}, 32'd1);
        chk("t1_busy",     {31'b0, busy}, 32'd0);
        chk("t1_terr",     {31'b0, timeout_err}, 32'd0);
        chk("t1_issued",   issued_count, 32'd3);
        chk("t1_pulses",   32'(tr_pulses - p0), 32'd3);
        chk("t1_mem_addr", mem_addr, 32'h300);
        repeat (3) tick();
        chk("t1_done_hold", {31'b0, done}, 32'd1);

        // Zero-length trace
        p0 = tr_pulses;
        r0 = rd_pulses;
        do_start(4'd0);
        chk("t3_done",   {31'b0, done}, 32'd1);
        chk("t3_busy",   {31'b0, busy}, 32'd0);
        chk("t3_issued", issued_count, 32'd0);
        chk("t3_rd_en",  {31'b0, rd_en}, 32'd0);
        tick();
        chk("t3_no_tr", 32'(tr_pulses - p0), 32'd0);
        chk("t3_no_rd", 32'(rd_pulses - r0), 32'd0);

        // Timeout: no response, error exactly 8 cycles after WAIT_RESP entry
        do_start(4'd2);
        issue_part(0, 32'h100, 1'b0, 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t4_terr_pending", {31'b0, timeout_err}, 32'd0);
            chk("t4_busy_pending", {31'b0, busy}, 32'd1);
        end
        tick();
        chk("t4_terr",   {31'b0, timeout_err}, 32'd1);
        chk("t4_done",   {31'b0, done}, 32'd1);
        chk("t4_issued", issued_count, 32'd1);
        tick();
        chk("t4_terr_sticky", {31'b0, timeout_err}, 32'd1);

        // Response in the timeout cycle takes priority
        do_start(4'd2);
        chk("t5_terr_cleared", {31'b0, timeout_err}, 32'd0);
        issue_part(0, 32'h100, 1'b0, 1);
        repeat (7) tick();
        found_in_cache = 1'b1;
        tick();
        found_in_cache = 1'b0;
        chk("t5_terr_prio", {31'b0, timeout_err}, 32'd0);
        entry(1, 32'h200, 0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
        chk("t5_done",   {31'b0, done}, 32'd1);
        chk("t5_terr",   {31'b0, timeout_err}, 32'd0);
        chk("t5_issued", issued_count, 32'd2);

        // Dual response and spurious responses in ISSUE give a single advance
        p0 = tr_pulses;
        do_start(4'd3);
        entry(0, 32'h100, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1);
        entry(1, 32'h200, 1, 1'b1, 1'b1, 1'b1, 1'b0, 2);
        entry(2, 32'h300, 2, 1'b1, 1'b1, 1'b1, 1'b0, 3);
        chk("t6_done",   {31'b0, done}, 32'd1);
        chk("t6_issued", issued_count, 32'd3);
        chk("t6_pulses", 32'(tr_pulses - p0), 32'd3);

        // Reset in WAIT_RESP of entry 2 of 5, with start and response asserted too
        do_start(4'd5);
        entry(0, 32'h100, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        issue_part(1, 32'h200, 1'b0, 2);
        tick();
        rst            = 1'b1;
        start          = 1'b1;
        trace_len      = 4'd3;
        found_in_cache = 1'b1;
        updated        = 1'b1;
        tick();
        chk_reset_outputs("t7_rst");
        rst            = 1'b0;
        start          = 1'b0;
        found_in_cache = 1'b0;
        updated        = 1'b0;
        p0 = tr_pulses;
        repeat (3) tick();
        chk("t7_idle_busy", {31'b0, busy}, 32'd0);
        chk("t7_no_tr",     32'(tr_pulses - p0), 32'd0);
        do_start(4'd2);
        entry(0, 32'h100, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        entry(1, 32'h200, 0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        chk("t7_replay_done",   {31'b0, done}, 32'd1);
        chk("t7_replay_issued", issued_count, 32'd2);

        // Start while busy is ignored
        p0 = tr_pulses;
        do_start(4'd3);
        entry(0, 32'h100, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        entry(1, 32'h200, 2, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        entry(2, 32'h300, 2, 1'b0, 1'b1, 1'b0, 1'b1, 3);
        chk("t8_done",   {31'b0, done}, 32'd1);
        chk("t8_issued", issued_count, 32'd3);
        chk("t8_pulses", 32'(tr_pulses - p0), 32'd3);

        // Full-depth trace: 2^IDX_W entries, idx must not wrap
        for (int i = 0; i < 8; i++) mem[i] = 32'hA000_0000 + 32'(i * 16);
        p0 = tr_pulses;
        do_start(4'd8);
        for (int i = 0; i < 8; i++) entry(i, mem[i], 0, 1'b1, 1'b0, 1'b0, 1'b0, i + 1);
        chk("t9_done",     {31'b0, done}, 32'd1);
        chk("t9_busy",     {31'b0, busy}, 32'd0);
        chk("t9_issued",   issued_count, 32'd8);
        chk("t9_pulses",   32'(tr_pulses - p0), 32'd8);
        chk("t9_mem_addr", mem_addr, 32'hA000_0070);
        tick();
        chk("t9_no_rd", {31'b0, rd_en}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
